// File: rtl/message_scroller.sv
// -----------------------------------------------------------------------------
// message_scroller
//    Drives an 8x8 LED matrix through two daisy-chained 74HC595 shift
//    registers.  Each row refresh shifts a 16-bit word {row one-hot, ~columns}
//    MSB first, latches it, then moves to the next row.  A dwell counter steps
//    through the stored message frames.  The source frames for a full 8-row
//    refresh are snapshotted at row 0, so the displayed image never tears.
//
//    Optional feature: define MESSAGE_SCROLLER_SCROLL_EN to scroll the message
//    one column per step instead of jumping a whole frame per step.
//
// Parameters
//    MSG_LEN    number of frames in the message (2..2**ADDR_W)
//    ADDR_W     frame address width
//    DWELL      sys_clk cycles per display step (>=16)
//    SRCLK_HALF sys_clk cycles per CLOCK half-period (>=1)
//
// Ports
//    sys_clk     single rising-edge clock
//    rst_n       asynchronous active-low reset
//    wr_en       frame write strobe
//    wr_addr     frame index to write (>= MSG_LEN ignored)
//    wr_data     frame bitmap, [63:56]=row 0, bit 7 of a byte = leftmost column
//    enable      low blanks the display and freezes the dwell counter
//    DATA        595 SER
//    CLOCK       595 SRCLK
//    LATCH       595 RCLK
//    OE          595 OE (active low)
//    CLEAR       595 SRCLR (active low)
//    char_index  frame currently selected for display
//    frame_done  one-cycle pulse per completed 8-row refresh
// -----------------------------------------------------------------------------
module message_scroller #(
   parameter int MSG_LEN    = 6,
   parameter int ADDR_W     = 3,
   parameter int DWELL      = 25_000_000,
   parameter int SRCLK_HALF = 2
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [63:0]       wr_data,
   input  logic              enable,
   output logic              DATA,
   output logic              CLOCK,
   output logic              LATCH,
   output logic              OE,
   output logic              CLEAR,
   output logic [ADDR_W-1:0] char_index,
   output logic              frame_done
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;
   localparam logic [1:0] ST_NEXT  = 2'd3;

   localparam int TW = $clog2(2 * SRCLK_HALF) + 1;
   localparam int DW = $clog2(DWELL);
   localparam logic [TW-1:0]     HALF_LAST  = TW'(SRCLK_HALF - 1);
   localparam logic [TW-1:0]     INIT_LAST  = TW'(2 * SRCLK_HALF - 1);
   localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(MSG_LEN - 1);
   localparam logic [ADDR_W:0]   MSG_LEN_W  = (ADDR_W + 1)'(MSG_LEN);

   logic [63:0]       frame_r [MSG_LEN];
   logic [63:0]       snap_cur_r;
   logic [63:0]       snap_nxt_r;
   logic [2:0]        snap_off_r;
   logic [1:0]        state_r;
   logic [TW-1:0]     tmr_r;
   logic [3:0]        bit_r;
   logic [2:0]        row_r;
   logic [DW-1:0]     dwell_r;
   logic [ADDR_W-1:0] char_index_r;
   logic              data_r;
   logic              clock_r;
   logic              latch_r;
   logic              oe_r;
   logic              clear_r;
   logic              frame_done_r;

   logic              wr_ok_s;
   logic [ADDR_W-1:0] nxt_idx_s;
   logic [63:0]       cur_src_s;
   logic [63:0]       nxt_src_s;
   logic [5:0]        row_base_s;
   logic [15:0]       pair_s;
   logic [7:0]        disp_s;
   logic [15:0]       word_s;
   logic [3:0]        bit_dec_s;
   logic              step_s;
   logic              adv_char_s;
   logic [2:0]        off_s;

   assign DATA       = data_r;
   assign CLOCK      = clock_r;
   assign LATCH      = latch_r;
   assign OE         = oe_r;
   assign CLEAR      = clear_r;
   assign char_index = char_index_r;
   assign frame_done = frame_done_r;

`ifdef MESSAGE_SCROLLER_SCROLL_EN
   logic [2:0] off_r;
   assign off_s = off_r;

   // Column offset: one column per step, wrapping 7 -> 0
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         off_r <= 3'd0;
      end else if (step_s) begin
         off_r <= off_r + 3'd1;
      end else begin
         off_r <= off_r;
      end
   end
`else
   assign off_s = 3'd0;
`endif

   // Write qualification, snapshot sources with same-cycle write forwarding, and row word
   always_comb begin
      wr_ok_s = wr_en && ({1'b0, wr_addr} < MSG_LEN_W);
      if (char_index_r == IDX_LAST) begin
         nxt_idx_s = '0;
      end else begin
         nxt_idx_s = char_index_r + ADDR_W'(1);
      end
      if (wr_ok_s && (wr_addr == char_index_r)) begin
         cur_src_s = wr_data;
      end else begin
         cur_src_s = frame_r[char_index_r];
      end
      if (wr_ok_s && (wr_addr == nxt_idx_s)) begin
         nxt_src_s = wr_data;
      end else begin
         nxt_src_s = frame_r[nxt_idx_s];
      end
      // Row r lives at bits [8*(7-r)+7 : 8*(7-r)]; 7-r is ~r for a 3-bit row
      row_base_s = {~row_r, 3'b000};
      // Upper byte of {cur,nxt}<<off equals (cur<<off)|(nxt>>(8-off))
      pair_s     = {snap_cur_r[row_base_s +: 8], snap_nxt_r[row_base_s +: 8]} << snap_off_r;
      disp_s     = pair_s[15:8];
      word_s     = {8'h80 >> row_r, ~disp_s};
      bit_dec_s  = bit_r - 4'd1;
      step_s     = enable && (dwell_r == DWELL_LAST);
`ifdef MESSAGE_SCROLLER_SCROLL_EN
      adv_char_s = step_s && (off_r == 3'd7);
`else
      adv_char_s = step_s;
`endif
   end

   // Frame storage
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            frame_r[i] <= 64'd0;
         end
      end else if (wr_ok_s) begin
         frame_r[wr_addr] <= wr_data;
      end else begin
         frame_r <= frame_r;
      end
   end

   // Dwell counter and displayed frame index
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_r      <= '0;
         char_index_r <= '0;
      end else begin
         if (enable) begin
            dwell_r <= step_s ? '0 : dwell_r + DW'(1);
         end else begin
            dwell_r <= dwell_r;
         end
         if (adv_char_s) begin
            char_index_r <= nxt_idx_s;
         end else begin
            char_index_r <= char_index_r;
         end
      end
   end

   // Output enable follows enable with one cycle of latency
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_r <= 1'b1;
      end else begin
         oe_r <= ~enable;
      end
   end

   // Refresh FSM: clear, shift 16 bits per row, latch, advance row
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_INIT;
         tmr_r        <= '0;
         bit_r        <= 4'd15;
         row_r        <= 3'd0;
         data_r       <= 1'b0;
         clock_r      <= 1'b0;
         latch_r      <= 1'b0;
         clear_r      <= 1'b0;
         frame_done_r <= 1'b0;
         snap_cur_r   <= 64'd0;
         snap_nxt_r   <= 64'd0;
         snap_off_r   <= 3'd0;
      end else begin
         frame_done_r <= 1'b0;
         case (state_r)
            ST_INIT: begin
               if (tmr_r == INIT_LAST) begin
                  state_r    <= ST_SHIFT;
                  tmr_r      <= '0;
                  clear_r    <= 1'b1;
                  row_r      <= 3'd0;
                  bit_r      <= 4'd15;
                  data_r     <= 1'b1;   // bit 15 of row 0 is its one-hot bit
                  snap_cur_r <= cur_src_s;
                  snap_nxt_r <= nxt_src_s;
                  snap_off_r <= off_s;
               end else begin
                  clear_r <= 1'b0;
                  tmr_r   <= tmr_r + TW'(1);
               end
            end
            ST_SHIFT: begin
               if (tmr_r == HALF_LAST) begin
                  tmr_r <= '0;
                  if (!clock_r) begin
                     clock_r <= 1'b1;
                  end else begin
                     // Falling edge: the only place DATA advances within a row
                     clock_r <= 1'b0;
                     if (bit_r == 4'd0) begin
                        state_r <= ST_LATCH;
                        latch_r <= 1'b1;
                     end else begin
                        bit_r  <= bit_dec_s;
                        data_r <= word_s[bit_dec_s];
                     end
                  end
               end else begin
                  tmr_r <= tmr_r + TW'(1);
               end
            end
            ST_LATCH: begin
               if (tmr_r == HALF_LAST) begin
                  tmr_r   <= '0;
                  latch_r <= 1'b0;
                  state_r <= ST_NEXT;
                  if (row_r == 3'd7) begin
                     frame_done_r <= 1'b1;
                  end else begin
                     frame_done_r <= 1'b0;
                  end
               end else begin
                  tmr_r <= tmr_r + TW'(1);
               end
            end
            ST_NEXT: begin
               state_r <= ST_SHIFT;
               tmr_r   <= '0;
               bit_r   <= 4'd15;
               row_r   <= row_r + 3'd1;
               data_r  <= (row_r == 3'd7);
               if (row_r == 3'd7) begin
                  snap_cur_r <= cur_src_s;
                  snap_nxt_r <= nxt_src_s;
                  snap_off_r <= off_s;
               end else begin
                  snap_off_r <= snap_off_r;
               end
            end
            default: begin
               state_r <= ST_INIT;
               tmr_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_message_scroller.sv
module tb_message_scroller;

   localparam int ML  = 3;
   localparam int AW  = 2;
   localparam int DWL = 20;
   localparam int H   = 2;
   localparam int P   = 33 * H + 1;   // cycles per row: 16 pulses, latch, next
   localparam int FR  = 8 * P;        // cycles per full refresh

   logic          sys_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          wr_en   = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [63:0]   wr_data = 64'd0;
   logic          enable  = 1'b0;
   logic          DATA, CLOCK, LATCH, OE, CLEAR, frame_done;
   logic [AW-1:0] char_index;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_k;
   logic [63:0] m_frame [ML];
   int          m_ci, m_off, m_en, m_soff;
   logic [63:0] m_cur, m_nxt;
   logic        m_oe;

   // serial decoder state
   logic [15:0] dec_word = 16'd0;
   logic        prev_clk = 1'b0;
   logic        prev_lat = 1'b0;
   logic        first_pending = 1'b0;
   logic        seen43 = 1'b0;

   message_scroller #(.MSG_LEN(ML), .ADDR_W(AW), .DWELL(DWL), .SRCLK_HALF(H)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .enable(enable), .DATA(DATA), .CLOCK(CLOCK),
      .LATCH(LATCH), .OE(OE), .CLEAR(CLEAR), .char_index(char_index),
      .frame_done(frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected 16-bit row word from the spec formula on the model snapshot
   function automatic logic [15:0] exp_word(input int row);
      logic [63:0] t;
      int c, n, d;
      t = m_cur >> (8 * (7 - row));
      c = int'(t[7:0]);
      t = m_nxt >> (8 * (7 - row));
      n = int'(t[7:0]);
      d = ((c << m_soff) | (n >> (8 - m_soff))) & 255;
      return 16'((1 << (15 - row)) | (~d & 255));
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge sys_clk);
         #1;
      end
   endtask

   // Reference model: edge count since reset, frames, dwell stepping, snapshots
   initial begin
      m_k = 0; m_ci = 0; m_off = 0; m_en = 0; m_soff = 0;
      m_cur = 64'd0; m_nxt = 64'd0; m_oe = 1'b1;
      for (int i = 0; i < ML; i++) m_frame[i] = 64'd0;
      forever begin
         @(posedge sys_clk or negedge rst_n);
         if (!rst_n) begin
            m_k = 0; m_ci = 0; m_off = 0; m_en = 0; m_soff = 0;
            m_cur = 64'd0; m_nxt = 64'd0; m_oe = 1'b1;
            for (int i = 0; i < ML; i++) m_frame[i] = 64'd0;
         end else begin
            if (wr_en && (int'(wr_addr) < ML)) m_frame[wr_addr] = wr_data;
            m_k = m_k + 1;
            if (m_k >= 2 * H && ((m_k - 2 * H) % FR) == 0) begin
               m_cur  = m_frame[m_ci];
               m_nxt  = m_frame[(m_ci + 1) % ML];
               m_soff = m_off;
            end
            m_oe = ~enable;
            if (enable) begin
               m_en = m_en + 1;
               if ((m_en % DWL) == 0) begin
`ifdef MESSAGE_SCROLLER_SCROLL_EN
                  m_off = (m_off + 1) % 8;
                  if (m_off == 0) m_ci = (m_ci + 1) % ML;
`else
                  m_ci = (m_ci + 1) % ML;
`endif
               end
            end
         end
      end
   end

   // Per-cycle checker, sampled on the falling edge
   initial begin
      int q, p, row, bi;
      logic e_clk, e_lat, e_fd;
      logic [15:0] w;
      forever begin
         @(negedge sys_clk);
         if (!rst_n) begin
            check_eq("rst_data", DATA, 1'b0);
            check_eq("rst_clock", CLOCK, 1'b0);
            check_eq("rst_latch", LATCH, 1'b0);
            check_eq("rst_oe", OE, 1'b1);
            check_eq("rst_clear", CLEAR, 1'b0);
            check_eq("rst_ci", char_index, 0);
            check_eq("rst_fd", frame_done, 1'b0);
            dec_word = 16'd0; prev_clk = 1'b0; prev_lat = 1'b0;
         end else begin
            check_eq("clear", CLEAR, (m_k >= 2 * H));
            check_eq("oe", OE, m_oe);
            check_eq("char_index", char_index, m_ci);
            e_clk = 1'b0; e_lat = 1'b0; e_fd = 1'b0; row = 0;
            if (m_k >= 2 * H) begin
               q   = m_k - 2 * H;
               p   = q % P;
               row = (q / P) % 8;
               e_clk = (p < 32 * H) && (((p / H) % 2) == 1);
               e_lat = (p >= 32 * H) && (p < 33 * H);
               e_fd  = (p == 33 * H) && (row == 7);
               if (p < 32 * H) begin
                  w  = exp_word(row);
                  bi = 15 - p / (2 * H);
                  check_eq("data", DATA, w[bi]);
               end
            end
            check_eq("clock", CLOCK, e_clk);
            check_eq("latch", LATCH, e_lat);
            check_eq("frame_done", frame_done, e_fd);
            if (CLOCK && !prev_clk) dec_word = {dec_word[14:0], DATA};
            if (LATCH && !prev_lat) begin
               if (first_pending) begin
                  check_eq("first_word", dec_word, 16'h807E);
                  first_pending = 1'b0;
               end
               check_eq("latched_word", dec_word, exp_word(row));
`ifdef MESSAGE_SCROLLER_SCROLL_EN
               if (row == 0 && m_soff == 4 && m_cur[63:56] == 8'hF0 && m_nxt[63:56] == 8'h0F) begin
                  check_eq("scroll_off4_cols", dec_word[7:0], 8'hFF);
                  seen43 = 1'b1;
               end
`endif
            end
            prev_clk = CLOCK;
            prev_lat = LATCH;
         end
      end
   end

   // Stimulus
   initial begin
      int cnt, fd_cnt, ci0, q, p, row;
      logic found;
      tick(3);
      // release with enable low; load frame 0 row 0 = 0x81 before the first snapshot
      rst_n = 1'b1;
      first_pending = 1'b1;
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = {8'h81, 56'd0};
      cnt = 0;
      while (!CLEAR && cnt < 20) begin
         tick(1);
         wr_en = 1'b0;
         cnt++;
      end
      check_eq("clear_hold_cycles", cnt, 2 * H);
      check_eq("oe_init", OE, 1'b1);
      enable = 1'b1;
      tick(2 * FR);
      check_eq("first_word_seen", first_pending, 1'b0);

      // randomized writes (including out-of-range addresses) and enable dropouts
      for (int i = 0; i < 5000; i++) begin
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_addr = AW'($urandom_range(0, 3));
         wr_data = {$urandom, $urandom};
         enable  = ($urandom_range(0, 15) != 0);
         tick(1);
      end
      wr_en = 1'b0;

      // display disabled: index frozen, refresh keeps running
      enable = 1'b0;
      tick(1);
      ci0 = int'(char_index);
      fd_cnt = 0;
      for (int i = 0; i < 2 * FR + 100; i++) begin
         tick(1);
         if (frame_done) fd_cnt++;
      end
      check_eq("oe_disabled", OE, 1'b1);
      check_eq("ci_frozen", char_index, ci0);
      check_eq("fd_while_disabled", (fd_cnt >= 2), 1'b1);

`ifdef MESSAGE_SCROLLER_SCROLL_EN
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = {8'hF0, 56'd0}; tick(1);
      wr_addr = 2'd1; wr_data = {8'h0F, 56'd0}; tick(1);
      wr_en = 1'b0;
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         tick(1);
         if (m_ci == 0 && m_off == 4) found = 1'b1;
      end
      enable = 1'b0;
      check_eq("wait_offset4", found, 1'b1);
      tick(2 * FR + 10);
      check_eq("scroll_off4_seen", seen43, 1'b1);
`endif

      // reset in the middle of bit 9 of row 3
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2 * FR && !found; i++) begin
         tick(1);
         if (m_k >= 2 * H) begin
            q = m_k - 2 * H; p = q % P; row = (q / P) % 8;
            if (row == 3 && p < 32 * H && (p / (2 * H)) == 6) found = 1'b1;
         end
      end
      check_eq("wait_row3_bit9", found, 1'b1);
      rst_n = 1'b0;
      tick(1);
      check_eq("midshift_rst_clock", CLOCK, 1'b0);
      check_eq("midshift_rst_clear", CLEAR, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(2 * FR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/message_scroller.md
MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 6, number of 8x8 frames in the message (2..2**ADDR_W).
REQ-002 The block SHALL have parameter ADDR_W, default 3, width of the frame address.
REQ-003 The block SHALL have parameter DWELL, default 25_000_000, sys_clk cycles per display step (>=16).
REQ-004 The block SHALL have parameter SRCLK_HALF, default 2, sys_clk cycles per CLOCK half-period (>=1).
REQ-005 The block SHALL have port sys_clk  in  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port wr_en  in  1  frame write strobe.
REQ-008 The block SHALL have port wr_addr  in  ADDR_W  frame index to write; writes with wr_addr>=MSG_LEN SHALL be ignored.
REQ-009 The block SHALL have port wr_data  in  64  frame bitmap: [63:56]=row 0 ... [7:0]=row 7; bit 7 of each byte = leftmost column; 1 = LED on.
REQ-010 The block SHALL have port enable  in  1  low = blank the display and freeze the dwell counter.
REQ-011 The block SHALL have port DATA  out  1  595 SER.
REQ-012 The block SHALL have port CLOCK  out  1  595 SRCLK.
REQ-013 The block SHALL have port LATCH  out  1  595 RCLK.
REQ-014 The block SHALL have port OE  out  1  595 OE, active low.
REQ-015 The block SHALL have port CLEAR  out  1  595 SRCLR, active low.
REQ-016 The block SHALL have port char_index  out  ADDR_W  frame currently displayed.
REQ-017 The block SHALL have port frame_done  out  1  one-cycle pulse per completed 8-row refresh.

Function
REQ-018 The block SHALL hold frame storage of MSG_LEN x 64-bit registers, written on sys_clk when wr_en=1.
REQ-019 The FSM SHALL have states INIT, SHIFT, LATCH, NEXT.
REQ-020 INIT SHALL hold CLEAR=0 for 2*SRCLK_HALF cycles, then go to SHIFT with row=0.
REQ-021 SHIFT SHALL emit a 16-bit word {onehot(row), ~col_bits}, bit 15 first, with 16 CLOCK pulses.
REQ-022 In SHIFT, DATA SHALL change only when CLOCK falls; CLOCK SHALL be low for SRCLK_HALF cycles and high for SRCLK_HALF cycles.
REQ-023 LATCH state SHALL drive LATCH=1 for SRCLK_HALF cycles, with CLOCK=0.
REQ-024 NEXT SHALL last 1 cycle and increment row.
REQ-025 In NEXT, row 7 SHALL wrap to 0 and frame_done SHALL pulse in that cycle.
REQ-026 At row 0 entry, the block SHALL snapshot frame[char_index], frame[(char_index+1) mod MSG_LEN] and the scroll offset, so the displayed image never tears.
REQ-027 Writes SHALL take effect at the next frame boundary, including writes to the displayed frame; a write in the snapshot cycle SHALL be visible in that snapshot.
REQ-028 When enable=1, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL wrap and raise one step.
REQ-029 Without scroll, a step SHALL advance char_index, wrapping MSG_LEN-1 -> 0.
REQ-030 Refresh SHALL run continuously regardless of enable.
REQ-031 OE SHALL be 0 while enable=1 and 1 while enable=0, registered with 1-cycle latency.
REQ-032 If step and wr_en occur in the same cycle, both SHALL take effect.

Reset
REQ-033 While rst_n=0: DATA=0, CLOCK=0, LATCH=0, OE=1, CLEAR=0, char_index=0, frame_done=0, counters=0, offset=0, all frames=0, state=INIT.
REQ-034 Reset mid-shift SHALL abort immediately; after release the FSM SHALL restart from INIT.

Configuration
REQ-035 The macro MESSAGE_SCROLLER_SCROLL_EN SHALL control scrolling.
REQ-036 When MESSAGE_SCROLLER_SCROLL_EN is defined, a step SHALL advance offset 0..7, shifting content left one column.
REQ-037 With scroll defined, displayed row r SHALL be (cur[r]<<offset)|(nxt[r]>>(8-offset)) truncated to 8 bits.
REQ-038 With scroll defined, when offset wraps 7 -> 0, char_index SHALL advance.
REQ-039 When MESSAGE_SCROLLER_SCROLL_EN is undefined, offset SHALL be constant 0 and the REQ-029 whole-frame stepping SHALL apply.

Verification
REQ-040 Bench: reset, then release -> CLEAR=0 for 4 cycles (SRCLK_HALF=2), OE=1, then first CLOCK rise.
REQ-041 Bench: frame0 row0=8'h81, enable=1 -> first 16 DATA bits sampled on CLOCK rise = 16'h807E, then LATCH pulse.
REQ-042 Bench: DWELL=20, MSG_LEN=3, no scroll -> char_index 0,1,2,0 at 20-cycle spacing; displayed frame changes only after frame_done.
REQ-043 Bench: scroll on, frame0 row0=8'hF0, frame1 row0=8'h0F, offset=4 -> column byte = ~8'h00 = 8'hFF.
REQ-044 Bench: enable low for 100 cycles -> OE=1, char_index frozen, frame_done keeps pulsing.
REQ-045 Bench: rst_n low during bit 9 of row 3 -> outputs at reset values; restart at INIT with row 0.
